// File: rtl/alu_sequencer.sv
// alu_sequencer: runs a small loaded program against an external registered ALU,
// writing each result back into a 4-entry register file and pulsing done at the end.
module alu_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int PA_W       = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prog_we,
    input  logic [PA_W-1:0] prog_addr,
    input  logic [15:0]     prog_data,
    input  logic [PA_W:0]   prog_len,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [3:0]      alu_opcode,
    input  logic [7:0]      alu_res,
    input  logic [1:0]      reg_sel,
    output logic [7:0]      reg_rdata,
    output logic [7:0]      last_res
);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [PA_W:0] DEPTH = (PA_W+1)'(PROG_DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WB, DONE} state_t;

    state_t          state, state_nx;
    logic [15:0]     mem [PROG_DEPTH];
    logic [15:0]     ir;
    logic [PA_W-1:0] pc;
    logic [PA_W:0]   len, len_clamped;
    logic [7:0]      rf [4];
    logic [CW-1:0]   cnt;
    logic            cnt_end, last_instr;

    assign len_clamped = (prog_len > DEPTH) ? DEPTH : prog_len;
    assign cnt_end     = cnt == CW'(ALU_LAT - 1);
    assign last_instr  = (PA_W+1)'(pc) + (PA_W+1)'(1) == len;
    assign reg_rdata   = rf[reg_sel];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        done     = state == DONE;
        case (state)
            IDLE:    if (start) state_nx = (len_clamped != '0) ? FETCH : DONE;
            FETCH:   state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt_end) state_nx = WB;
            WB:      state_nx = last_instr ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Program memory keeps its contents across reset.
    always_ff @(posedge clk)
        if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            len        <= '0;
            ir         <= '0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            last_res   <= '0;
            rf         <= '{default: '0};
        end else begin
            case (state)
                IDLE: if (start) begin
                    len <= len_clamped;
                    pc  <= '0;
                end
                FETCH: ir <= mem[pc];
                ISSUE: begin
                    alu_a      <= rf[ir[9:8]];
                    alu_b      <= ir[7:0];
                    alu_opcode <= ir[15:12];
                    cnt        <= '0;
                end
                WAIT: if (!cnt_end) cnt <= cnt + CW'(1);
                WB: begin
                    rf[ir[11:10]] <= alu_res;
                    last_res      <= alu_res;
                    if (!last_instr) pc <= pc + PA_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives two sequencers (ALU_LAT 1 and 3) with behavioural ALUs and
// checks them against a program-level reference model.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [15:0] prog_data;
    logic [4:0] prog_len;
    logic       start;
    logic [1:0] reg_sel;

    logic       busy1, done1, busy3, done3;
    logic [7:0] alu_a1, alu_b1, alu_res1, reg_rdata1, last_res1;
    logic [7:0] alu_a3, alu_b3, alu_res3, reg_rdata3, last_res3;
    logic [3:0] alu_opcode1, alu_opcode3;
    logic [7:0] pipe3 [3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem_m [16];
    logic [7:0]  rf_m [4];
    logic [7:0]  last_m;
    logic [3:0]  last_op_m;

    typedef struct {
        logic [15:0] word;
        logic [1:0]  rd;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl [3];

    always #5 clk = ~clk;

    alu_sequencer #(.PROG_DEPTH(16), .PA_W(4), .ALU_LAT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .busy(busy1),
        .done(done1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_opcode1),
        .alu_res(alu_res1), .reg_sel(reg_sel), .reg_rdata(reg_rdata1), .last_res(last_res1)
    );

    alu_sequencer #(.PROG_DEPTH(16), .PA_W(4), .ALU_LAT(3)) d3 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .busy(busy3),
        .done(done3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3),
        .alu_res(alu_res3), .reg_sel(reg_sel), .reg_rdata(reg_rdata3), .last_res(last_res3)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << 1;
            4'h6: return a >> 1;
            4'h7: return {7'd0, a == b};
            4'h8: return {7'd0, a < b};
            4'h9: return b - a;
            4'hA: return ~a;
            4'hB: return b;
            4'hC: return ~(a ^ b);
            4'hD: return a + 8'd1;
            4'hE: return {a[3:0], b[3:0]};
            default: return a | ~b;
        endcase
    endfunction

    // ALUs with 1 and 3 register stages between operands and result.
    always_ff @(posedge clk) alu_res1 <= alu_f(alu_opcode1, alu_a1, alu_b1);
    always_ff @(posedge clk) begin
        pipe3[0] <= alu_f(alu_opcode3, alu_a3, alu_b3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign alu_res3 = pipe3[2];

    function automatic void model_reset();
        rf_m      = '{default: 8'h00};
        last_m    = 8'h00;
        last_op_m = 4'h0;
    endfunction

    function automatic void model_run(input int n);
        int          ne;
        logic [15:0] w;
        logic [7:0]  r;
        ne = (n > 16) ? 16 : n;
        for (int i = 0; i < ne; i++) begin
            w = mem_m[i];
            r = alu_f(w[15:12], rf_m[w[9:8]], w[7:0]);
            rf_m[w[11:10]] = r;
            last_m    = r;
            last_op_m = w[15:12];
        end
    endfunction

    function automatic int exp_cyc(input int n, input int lat);
        int ne;
        ne = (n > 16) ? 16 : n;
        return (ne == 0) ? 1 : ne * (lat + 3) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            reg_sel = 2'(i);
            #1;
            chk($sformatf("%s_reg%0d", tag, i), 32'(reg_rdata1), 32'(rf_m[i]));
        end
        chk({tag, "_last_res"}, 32'(last_res1), 32'(last_m));
    endtask

    // inj>0: at that cycle pulse a write to mem[1] and hold start high through DONE.
    task automatic run(input logic [4:0] n, input bit use3, input int inj, output int cyc, output bit busy_ok);
        prog_len = n; start = 1'b1; cyc = 0; busy_ok = 1'b1;
        forever begin
            tick();
            start = (inj > 0 && cyc + 1 >= inj);
            prog_we = 1'b0;
            cyc++;
            if ((use3 ? busy3 : busy1) !== 1'b1) busy_ok = 1'b0;
            if ((use3 ? done3 : done1) === 1'b1 || cyc >= 200) break;
            if (cyc == inj) begin
                prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'hFFFF;
            end
        end
        tick();
        start = 1'b0;
        chk("busy_after_done", 32'(use3 ? busy3 : busy1), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        bit         bok;
        bit         stable_ok, early_done;
        logic [4:0] n;

        tbl[0] = '{16'h0005, 2'd0, 8'd5};
        tbl[1] = '{16'h0403, 2'd1, 8'd8};
        tbl[2] = '{16'h1901, 2'd2, 8'd7};

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; reg_sel = '0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_alu_a", 32'(alu_a1), 32'd0);
        chk("rst_alu_b", 32'(alu_b1), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode1), 32'd0);
        check_regs("rst");

        // Three-instruction program, expectations from the table
        for (int i = 0; i < 3; i++) load(4'(i), tbl[i].word);
        run(5'd3, 1'b0, 0, cyc, bok);
        chk("prog3_cycles", 32'(cyc), 32'd13);
        chk("prog3_busy", 32'(bok), 32'd1);
        for (int i = 0; i < 3; i++) begin
            reg_sel = tbl[i].rd;
            #1;
            chk($sformatf("prog3_tbl%0d", i), 32'(reg_rdata1), 32'(tbl[i].exp));
        end
        chk("prog3_last_res", 32'(last_res1), 32'd7);
        model_run(3);

        // Zero-length run
        run(5'd0, 1'b0, 0, cyc, bok);
        chk("len0_cycles", 32'(cyc), 32'd1);
        chk("len0_busy", 32'(bok), 32'd1);
        chk("len0_opcode", 32'(alu_opcode1), 32'(last_op_m));
        check_regs("len0");

        // start/prog_we while busy, start held through DONE
        do_reset();
        run(5'd3, 1'b0, 5, cyc, bok);
        model_run(3);
        chk("inject_cycles", 32'(cyc), 32'd13);
        chk("inject_busy", 32'(bok), 32'd1);
        check_regs("inject");

        // Asynchronous reset during WAIT of instruction 2
        do_reset();
        prog_len = 5'd3; start = 1'b1; reg_sel = 2'd0;
        for (int c = 0; c < 7; c++) begin
            tick();
            start = 1'b0;
        end
        chk("midrst_pre_alu_b", 32'(alu_b1), 32'd3);
        chk("midrst_pre_reg0", 32'(reg_rdata1), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_done", 32'(done1), 32'd0);
        chk("midrst_alu_a", 32'(alu_a1), 32'd0);
        chk("midrst_alu_b", 32'(alu_b1), 32'd0);
        chk("midrst_opcode", 32'(alu_opcode1), 32'd0);
        chk("midrst_last_res", 32'(last_res1), 32'd0);
        chk("midrst_reg0", 32'(reg_rdata1), 32'd0);
        rst_n = 1'b1;
        model_reset();
        tick();
        run(5'd3, 1'b0, 0, cyc, bok);
        model_run(3);
        chk("rerun_cycles", 32'(cyc), 32'd13);
        check_regs("rerun");

        // ALU_LAT=3: reg0=0x0F then XOR rd3 ra0 0xAA
        do_reset();
        load(4'd0, 16'h010F);
        run(5'd1, 1'b1, 0, cyc, bok);
        chk("lat3_setup_cycles", 32'(cyc), 32'd7);
        load(4'd0, 16'h4CAA);
        prog_len = 5'd1; start = 1'b1; stable_ok = 1'b1; early_done = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
            if (c >= 3 && c <= 6 && {alu_a3, alu_b3, alu_opcode3} !== {8'h0F, 8'hAA, 4'h4}) stable_ok = 1'b0;
            if (c < 7 && done3 !== 1'b0) early_done = 1'b1;
        end
        chk("lat3_done", 32'(done3), 32'd1);
        chk("lat3_early_done", 32'(early_done), 32'd0);
        chk("lat3_alu_stable", 32'(stable_ok), 32'd1);
        tick();
        reg_sel = 2'd3;
        #1;
        chk("lat3_reg3", 32'(reg_rdata3), 32'hA5);
        chk("lat3_busy_after", 32'(busy3), 32'd0);

        // prog_len beyond depth clamps to 16 instructions
        do_reset();
        for (int a = 0; a < 16; a++) load(4'(a), 16'h0001);
        run(5'd31, 1'b0, 0, cyc, bok);
        chk("clamp_cycles", 32'(cyc), 32'd65);
        reg_sel = 2'd0;
        #1;
        chk("clamp_reg0", 32'(reg_rdata1), 32'd16);
        model_reset();
        model_run(31);

        // Random programs and lengths against the reference model
        for (int it = 0; it < 8; it++) begin
            if (it % 2 == 0)
                for (int a = 0; a < 16; a++) load(4'(a), 16'($urandom));
            n = 5'($urandom_range(0, 31));
            run(n, 1'b0, 0, cyc, bok);
            model_run(int'(n));
            chk($sformatf("rand%0d_cycles", it), 32'(cyc), 32'(exp_cyc(int'(n), 1)));
            chk($sformatf("rand%0d_busy", it), 32'(bok), 32'd1);
            chk($sformatf("rand%0d_opcode", it), 32'(alu_opcode1), 32'(last_op_m));
            check_regs($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
